// File: rtl/nios_dbg_cmd_bridge.sv
// nios_dbg_cmd_bridge: system-clock side of the Nios II JTAG debug slave.
// Synchronises the virtual-JTAG update strobes, captures {ir_in, sr} on each
// update-DR edge into a first-word-fall-through FIFO, and decodes the head
// command into a one-hot action pulse when the consumer accepts it.
module nios_dbg_cmd_bridge #(
  parameter  int DATA_W      = 38,
  parameter  int IR_W        = 2,
  parameter  int SYNC_STAGES = 2,
  parameter  int FIFO_DEPTH  = 4,
  localparam int ACT_W       = 2 ** IR_W,
  localparam int LW          = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vs_udr,
  input  logic              vs_uir,
  input  logic [IR_W-1:0]   ir_in,
  input  logic [DATA_W-1:0] sr,
  output logic              cmd_valid,
  output logic [IR_W-1:0]   cmd_ir,
  output logic [DATA_W-1:0] cmd_data,
  input  logic              cmd_ready,
  output logic [ACT_W-1:0]  take_action,
  output logic              ir_update,
  output logic [LW-1:0]     fifo_level,
  output logic              overflow,
  input  logic              clr_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(SYNC_STAGES + 2);
  localparam int EW = IR_W + DATA_W;

  logic [SYNC_STAGES-1:0] udr_sync_q, udr_sync_d;
  logic [SYNC_STAGES-1:0] uir_sync_q, uir_sync_d;
  logic                   udr_prev_q, udr_prev_d;
  logic                   uir_prev_q, uir_prev_d;
  logic [CW-1:0]          arm_q, arm_d;
  logic                   ir_update_q, ir_update_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]          level_q, level_d;
  logic                   overflow_q, overflow_d;
  logic [EW-1:0]          mem_q [FIFO_DEPTH];

  logic          armed;
  logic          udr_edge;
  logic          uir_edge;
  logic          full;
  logic          push;
  logic          pop;
  logic          drop;
  logic [EW-1:0] head;

  // Synchroniser chains, edge detection and the post-reset arm counter.
  // Edges are suppressed until the chains have fully refilled after reset, so
  // a level that was already high at reset release never looks like an edge.
  always_comb begin
    udr_sync_d = {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
    uir_sync_d = {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
    udr_prev_d = udr_sync_q[SYNC_STAGES-1];
    uir_prev_d = uir_sync_q[SYNC_STAGES-1];
    armed      = (arm_q == CW'(SYNC_STAGES + 1));
    arm_d      = armed ? arm_q : arm_q + CW'(1);
    udr_edge   = armed & udr_sync_q[SYNC_STAGES-1] & ~udr_prev_q;
    uir_edge   = armed & uir_sync_q[SYNC_STAGES-1] & ~uir_prev_q;
    ir_update_d = uir_edge;
  end

  // FIFO control: a push into a full FIFO survives only if a pop frees a slot
  // in the same cycle; otherwise it is dropped and the sticky flag is set.
  // A set beats a simultaneous clear.
  always_comb begin
    pop        = (level_q != '0) & cmd_ready;
    full       = (level_q == LW'(FIFO_DEPTH));
    push       = udr_edge & (~full | pop);
    drop       = udr_edge & full & ~pop;
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d    = level_q + LW'(push) - LW'(pop);
    overflow_d = drop ? 1'b1 : (clr_overflow ? 1'b0 : overflow_q);
  end

  // Control state; all of it returns to idle on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      udr_sync_q  <= '0;
      uir_sync_q  <= '0;
      udr_prev_q  <= 1'b0;
      uir_prev_q  <= 1'b0;
      arm_q       <= '0;
      ir_update_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      udr_sync_q  <= udr_sync_d;
      uir_sync_q  <= uir_sync_d;
      udr_prev_q  <= udr_prev_d;
      uir_prev_q  <= uir_prev_d;
      arm_q       <= arm_d;
      ir_update_q <= ir_update_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
    end
  end

  // Command storage; contents are don't-care until written, outputs are gated.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {ir_in, sr};
    end
  end

  // Head presentation and one-hot action decode of the accepted command.
  always_comb begin
    head        = mem_q[rd_ptr_q];
    cmd_valid   = (level_q != '0);
    cmd_ir      = cmd_valid ? head[EW-1:DATA_W] : '0;
    cmd_data    = cmd_valid ? head[DATA_W-1:0]  : '0;
    take_action = '0;
    for (int i = 0; i < ACT_W; i++) begin
      take_action[i] = pop & (cmd_ir == IR_W'(i));
    end
  end

  assign ir_update  = ir_update_q;
  assign fifo_level = level_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_nios_dbg_cmd_bridge.sv
// Scoreboard bench for nios_dbg_cmd_bridge with default parameters.
module tb_nios_dbg_cmd_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        vs_udr;
  logic        vs_uir;
  logic [1:0]  ir_in;
  logic [37:0] sr;
  logic        cmd_valid;
  logic [1:0]  cmd_ir;
  logic [37:0] cmd_data;
  logic        cmd_ready;
  logic [3:0]  take_action;
  logic        ir_update;
  logic [2:0]  fifo_level;
  logic        overflow;
  logic        clr_overflow;

  int n_vec  = 0;
  int n_fail = 0;
  logic [39:0] exp_q [$];

  nios_dbg_cmd_bridge dut (
    .clk          (clk),
    .reset        (reset),
    .vs_udr       (vs_udr),
    .vs_uir       (vs_uir),
    .ir_in        (ir_in),
    .sr           (sr),
    .cmd_valid    (cmd_valid),
    .cmd_ir       (cmd_ir),
    .cmd_data     (cmd_data),
    .cmd_ready    (cmd_ready),
    .take_action  (take_action),
    .ir_update    (ir_update),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance n clock edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic udr_pulse(input logic [1:0] ir, input logic [37:0] data, input bit expect_push);
    if (expect_push) exp_q.push_back({ir, data});
    ir_in  = ir;
    sr     = data;
    vs_udr = 1'b1;
    tick(4);
    vs_udr = 1'b0;
    tick(4);
  endtask

  // Monitor: every accepted head must match the oldest expected command.
  always @(negedge clk) begin
    if (!reset && cmd_valid && cmd_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_pop: got ir=%0d data=0x%0h, expected no command", cmd_ir, cmd_data);
      end else begin
        logic [39:0] e;
        e = exp_q.pop_front();
        check("pop_ir", cmd_ir, e[39:38]);
        check("pop_data", cmd_data, e[37:0]);
        check("pop_action", take_action, 4'b0001 << e[39:38]);
      end
    end else begin
      check("idle_action", take_action, 0);
    end
  end

  initial begin
    bit seen;
    reset = 1'b1; vs_udr = 1'b1; vs_uir = 1'b1; ir_in = 2'd1; sr = 38'h0;
    cmd_ready = 1'b0; clr_overflow = 1'b0;
    tick(3);
    check("rst_valid", cmd_valid, 0);
    check("rst_level", fifo_level, 0);
    check("rst_overflow", overflow, 0);
    check("rst_ir_update", ir_update, 0);
    check("rst_cmd_ir", cmd_ir, 0);
    check("rst_cmd_data", cmd_data, 0);

    // Levels already high at reset release must not create commands.
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 10) begin vs_udr = 1'b0; vs_uir = 1'b0; end
      tick(1);
      if (cmd_valid || ir_update || fifo_level != 0) seen = 1'b1;
    end
    check("arm_no_event", seen, 0);
    check("arm_overflow", overflow, 0);

    // Single command with ready high: latency and one-cycle action.
    cmd_ready = 1'b1;
    exp_q.push_back({2'd2, 38'h15_5555_5555});
    ir_in = 2'd2; sr = 38'h15_5555_5555; vs_udr = 1'b1;
    tick(1); check("lat_e1_valid", cmd_valid, 0);
    tick(1); check("lat_e2_valid", cmd_valid, 0);
    tick(1); check("lat_e3_valid", cmd_valid, 1);
    check("lat_e3_ir", cmd_ir, 2);
    check("lat_e3_data", cmd_data, 38'h15_5555_5555);
    check("lat_e3_action", take_action, 4'b0100);
    tick(1); check("lat_e4_valid", cmd_valid, 0);
    check("lat_e4_action", take_action, 0);
    tick(2);
    vs_udr = 1'b0;
    tick(5);

    // Five commands into a 4-deep FIFO with no consumer.
    cmd_ready = 1'b0;
    for (int i = 0; i < 5; i++) udr_pulse(2'(i % 4), 38'h100 + 38'(i), i < 4);
    tick(2);
    check("ovf_level", fifo_level, 4);
    check("ovf_flag", overflow, 1);
    cmd_ready = 1'b1;
    tick(8);
    cmd_ready = 1'b0;
    check("ovf_drain_level", fifo_level, 0);
    check("ovf_drain_queue", exp_q.size(), 0);
    check("ovf_sticky", overflow, 1);
    clr_overflow = 1'b1; tick(1); clr_overflow = 1'b0;
    check("ovf_cleared", overflow, 0);

    // Full FIFO with a pop in the exact cycle of the new edge.
    for (int i = 0; i < 4; i++) udr_pulse(2'((i + 1) % 4), 38'h2A0 + 38'(i), 1'b1);
    exp_q.push_back({2'd3, 38'h3F_0000_0001});
    ir_in = 2'd3; sr = 38'h3F_0000_0001; vs_udr = 1'b1;
    tick(2);
    cmd_ready = 1'b1;
    tick(1);
    cmd_ready = 1'b0;
    check("fullpop_level", fifo_level, 4);
    check("fullpop_overflow", overflow, 0);
    tick(2);
    vs_udr = 1'b0;
    tick(4);
    check("fullpop_level_hold", fifo_level, 4);
    cmd_ready = 1'b1;
    tick(8);
    cmd_ready = 1'b0;
    check("fullpop_drain_level", fifo_level, 0);
    check("fullpop_drain_queue", exp_q.size(), 0);

    // ir_update pulse timing.
    vs_uir = 1'b1;
    tick(1); check("iru_e1", ir_update, 0);
    tick(1); check("iru_e2", ir_update, 0);
    tick(1); check("iru_e3", ir_update, 1);
    tick(1); check("iru_e4", ir_update, 0);
    tick(1);
    vs_uir = 1'b0;
    tick(5);
    check("iru_level", fifo_level, 0);

    // Clear coinciding with an overflow drop: set wins.
    for (int i = 0; i < 4; i++) udr_pulse(2'(3 - i), 38'h0C00 + 38'(i), 1'b1);
    ir_in = 2'd1; sr = 38'h0BAD; vs_udr = 1'b1;
    tick(2);
    clr_overflow = 1'b1;
    tick(1);
    clr_overflow = 1'b0;
    check("clrset_overflow", overflow, 1);
    check("clrset_level", fifo_level, 4);
    tick(2);
    vs_udr = 1'b0;
    tick(4);
    cmd_ready = 1'b1;
    tick(8);
    cmd_ready = 1'b0;
    check("clrset_drain_level", fifo_level, 0);
    clr_overflow = 1'b1; tick(1); clr_overflow = 1'b0;

    // Reset with three entries queued, then a single fresh command.
    for (int i = 0; i < 3; i++) udr_pulse(2'(i), 38'h0D00 + 38'(i), 1'b1);
    check("prerst_level", fifo_level, 3);
    reset = 1'b1;
    tick(1);
    exp_q.delete();
    check("midrst_level", fifo_level, 0);
    check("midrst_valid", cmd_valid, 0);
    reset = 1'b0;
    tick(5);
    udr_pulse(2'd2, 38'h1_2345, 1'b1);
    tick(1);
    check("postrst_level", fifo_level, 1);
    cmd_ready = 1'b1;
    tick(4);
    cmd_ready = 1'b0;
    check("postrst_drain_level", fifo_level, 0);
    check("postrst_queue", exp_q.size(), 0);
    check("postrst_overflow", overflow, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
